mt_result_display: RTL

- Downstream consumer of the practical-midterm adder stage. Takes its 3-bit result {cout, sum[1:0]} and captures it on a debounced push-button strobe.
- Keeps a saturating running total of captured results.
- Drives a 4-digit, time-multiplexed, active-low seven-segment display. Sits between the adder stage and the board display pins.

---
 rtl/mt_result_display_if.sv | 23 ++
 rtl/mt_result_display.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mt_result_display_if.sv
// Adder-result and display-pin bundle for mt_result_display.
// master drives the adder/button side, slave is the display block.
interface mt_result_display_if;
  logic [1:0] sum;
  logic       cout;
  logic       btn;
  logic [2:0] latest;
  logic [7:0] acc;
  logic       cap;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output sum, cout, btn,
    input  latest, acc, cap, seg, an, dp
  );

  modport slave (
    input  sum, cout, btn,
    output latest, acc, cap, seg, an, dp
  );
endinterface

// File: rtl/mt_result_display.sv
// Captures adder results on a debounced button, keeps a saturating
// total and scans it onto a 4-digit display. Option: MT_DISP_SAT_DP_EN.
module mt_result_display #(
  parameter int DB_CYCLES   = 250000,
  parameter int REFRESH_DIV = 100000,
  parameter int ACC_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  mt_result_display_if.slave io
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RFW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [RFW-1:0] RF_LAST = RFW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    DIG0      = 2'd0,
    DIG1      = 2'd1,
    DIG_BLANK = 2'd2,
    DIG3      = 2'd3
  } dig_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic           btn_s1_q, btn_s2_q;
  logic [1:0]     vld_q,    vld_d;
  logic           arm_q,    arm_d;
  logic           db_q,     db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           stb_q,    stb_d;

  logic [2:0]       latest_q, latest_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic             cap_q,    cap_d;
  logic [2:0]       res_in;
  logic [ACC_W:0]   acc_sum;

  logic [RFW-1:0] rf_cnt_q, rf_cnt_d;
  dig_t           dig_q,    dig_d;
  logic [6:0]     seg_q,    seg_d;
  logic [3:0]     an_q,     an_d;
  logic           tick;

  // Button sync; vld marks when the sync chain holds real samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      vld_q    <= '0;
    end else begin
      btn_s1_q <= io.btn;
      btn_s2_q <= btn_s1_q;
      vld_q    <= vld_d;
    end
  end

  assign vld_d = {vld_q[0], 1'b1};

  // Debounce; a held-at-reset button must be seen low before arming
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    stb_d    = 1'b0;
    arm_d    = arm_q | (vld_q[1] & ~btn_s2_q);
    if (btn_s2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = ~db_q;
      db_cnt_d = '0;
      stb_d    = ~db_q & arm_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      stb_q    <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      stb_q    <= stb_d;
      arm_q    <= arm_d;
    end
  end

  assign res_in  = {io.cout, io.sum};
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(res_in);

  // Capture on strobe with a clamped running total
  always_comb begin
    latest_d = latest_q;
    acc_d    = acc_q;
    cap_d    = 1'b0;
    if (stb_q) begin
      latest_d = res_in;
      acc_d    = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      cap_d    = 1'b1;
    end
  end

  // Capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latest_q <= '0;
      acc_q    <= '0;
      cap_q    <= 1'b0;
    end else begin
      latest_q <= latest_d;
      acc_q    <= acc_d;
      cap_q    <= cap_d;
    end
  end

  assign tick = (rf_cnt_q == RF_LAST);

  // Slot timer; on each tick drive the current digit and advance
  always_comb begin
    rf_cnt_d = tick ? '0 : rf_cnt_q + 1'b1;
    dig_d    = dig_q;
    seg_d    = seg_q;
    an_d     = an_q;
    if (tick) begin
      dig_d = dig_t'(dig_q + 2'd1);
      unique case (dig_q)
        DIG0: begin
          an_d  = 4'b1110;
          seg_d = hex7(acc_q[3:0]);
        end
        DIG1: begin
          an_d  = 4'b1101;
          seg_d = hex7(acc_q[7:4]);
        end
        DIG_BLANK: begin
          an_d  = 4'b1111;
          seg_d = 7'h7F;
        end
        DIG3: begin
          an_d  = 4'b0111;
          seg_d = hex7({1'b0, latest_q});
        end
      endcase
    end
  end

  // Scan registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_cnt_q <= '0;
      dig_q    <= DIG0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
    end else begin
      rf_cnt_q <= rf_cnt_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

`ifdef MT_DISP_SAT_DP_EN
  logic dp_q, dp_d;

  // Light the point in the high-digit slot once the total is pinned
  always_comb begin
    dp_d = dp_q;
    if (tick) begin
      dp_d = ~((dig_q == DIG1) & (&acc_q));
    end
  end

  // Decimal point register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign io.dp = dp_q;
`else
  assign io.dp = 1'b1;
`endif

  assign io.latest = latest_q;
  assign io.acc    = acc_q;
  assign io.cap    = cap_q;
  assign io.seg    = seg_q;
  assign io.an     = an_q;

endmodule
